mem_wb_bridge: RTL and testbench

- Responder on the PicoRV32 native memory bus and initiator on a classic single-beat Wishbone bus.
- Used for the SDRAM window (0x0300_0000–0x03FF_FFFF) in front of the SDRAM Wishbone controller.
- The downstream slave has no byte selects, so sub-word CPU stores become read-modify-write sequences.
- Single clock domain; all Wishbone and CPU-side outputs are registered.

---
 rtl/mem_wb_pkg.sv | 32 +++
 rtl/wb_byte_merge.sv | 13 +
 rtl/mem_wb_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_mem_wb_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and helpers for the PicoRV32-to-Wishbone bridge.
// The bridge's optional ack timeout is enabled by defining MEM_WB_BRIDGE_TIMEOUT_EN.
package mem_wb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRmwRd,
    StRmwGap,
    StRmwWr,
    StDone
  } state_e;

  localparam logic [7:0]  BaseHiDefault = 8'h03;
  localparam logic [31:0] TimeoutFill   = 32'hDEADBEEF;

  // Byte i of the result comes from new_word when strb[i] is set, else from old_word.
  function automatic logic [31:0] merge_bytes(input logic [3:0]  strb,
                                              input logic [31:0] new_word,
                                              input logic [31:0] old_word);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte-strobe merge for bridges in front of slaves without byte selects.
module wb_byte_merge
  import mem_wb_pkg::*;
(
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] new_i,
  input  logic [31:0] old_i,
  output logic [31:0] merged_o
);

  assign merged_o = merge_bytes(wstrb_i, new_i, old_i);

endmodule

// File: rtl/mem_wb_bridge.sv
// PicoRV32 native bus responder to single-beat Wishbone initiator; sub-word stores become RMW.
// Define MEM_WB_BRIDGE_TIMEOUT_EN to add a per-access ack timeout and the sticky err_o flag.
module mem_wb_bridge
  import mem_wb_pkg::*;
#(
  parameter logic [7:0]  BASE_HI        = BaseHiDefault,
  parameter int unsigned WB_AW          = 21,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic [WB_AW-1:0] wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i,
  output logic             busy,
  output logic             err_o
);

  state_e            state_q, state_d;
  logic [WB_AW-1:0]  adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       dat_q, dat_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              sel;
  logic              ack_ok;
  logic [31:0]       merged;

  assign sel    = mem_valid && (mem_addr[31:24] == BASE_HI);
  assign ack_ok = wb_ack_i && cyc_q;

  wb_byte_merge u_merge (
    .wstrb_i  (wstrb_q),
    .new_i    (wdata_q),
    .old_i    (wb_dat_i),
    .merged_o (merged)
  );

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    ready_d = 1'b0;
`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (sel) begin
          adr_d   = mem_addr[WB_AW+1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cyc_d   = 1'b1;
          if (mem_wstrb == 4'h0) begin
            state_d = StRd;
            we_d    = 1'b0;
          end else if (mem_wstrb == 4'hF) begin
            state_d = StWr;
            we_d    = 1'b1;
            dat_d   = mem_wdata;
          end else begin
            state_d = StRmwRd;
            we_d    = 1'b0;
          end
        end
      end
      StRd: begin
        if (ack_ok) begin
          rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          state_d = StDone;
        end
      end
      StWr, StRmwWr: begin
        if (ack_ok) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = StDone;
        end
      end
      StRmwRd: begin
        if (ack_ok) begin
          dat_d   = merged;
          cyc_d   = 1'b0;
          state_d = StRmwGap;
        end
      end
      StRmwGap: begin
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        state_d = StRmwWr;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
    if (cyc_d && !cyc_q) begin
      timer_d = '0;
    end else if (cyc_q && !ack_ok) begin
      if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
        // Abandon the beat; a stalled RMW read never reaches its write phase.
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        ready_d = 1'b1;
        err_d   = 1'b1;
        state_d = StDone;
        if (state_q == StRd) begin
          rdata_d = TimeoutFill;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      adr_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Byte-lane and out-of-window address bits have no function downstream.
  logic unused_addr;
  assign unused_addr = ^mem_addr[23:0];

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_wb_bridge.sv
// Randomized bench for mem_wb_bridge against a word-level memory model and a latency formula.
module tb_mem_wb_bridge;

  localparam int unsigned WbAw = 21;
  localparam int unsigned ToCycles = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wstrb = '0;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [WbAw-1:0] wb_adr_o;
  logic [31:0]     wb_dat_o;
  logic [31:0]     wb_dat_i = '0;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic            wb_ack_i = 1'b0;
  logic            busy;
  logic            err_o;

  mem_wb_bridge #(
    .BASE_HI        (8'h03),
    .WB_AW          (WbAw),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_ack_i  (wb_ack_i),
    .busy      (busy),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] slave_mem [int];
  logic [31:0] ref_mem   [int];
  logic [31:0] last_rd = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sget(input int i);
    return slave_mem.exists(i) ? slave_mem[i] : 32'h0;
  endfunction

  function automatic logic [31:0] rget(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  // One CPU access; slave acks in cycle n+1 of every beat. rst_gap resets during the RMW gap.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int n, input bit rst_gap);
    int          widx, k, cyc_cnt, beats, exp_beats, exp_lat;
    bit          done, stb_bad;
    logic [31:0] old_w, exp_w, exp_rd;
    widx  = int'(addr[22:2]);
    old_w = rget(widx);
    for (int b = 0; b < 4; b++) begin
      exp_w[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_w[8*b +: 8];
    end
    exp_beats = (strb == 4'h0 || strb == 4'hF) ? 1 : 2;
    exp_lat   = (exp_beats == 1) ? n + 2 : 2 * n + 4;
    exp_rd    = (strb == 4'h0) ? old_w : last_rd;

    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    @(posedge clk);
    k = 0; cyc_cnt = 0; beats = 0; done = 0; stb_bad = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      mem_wdata       = $urandom;
      mem_addr[15:0]  = 16'($urandom);
      if (wb_stb_o !== wb_cyc_o) stb_bad = 1;
      if (rst_gap && k == n + 2) begin
        check_eq("gap_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check_eq("gap_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1; mem_valid = 1'b0; wb_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check_eq("rst_ready", {31'b0, mem_ready}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_nowrite", sget(widx), old_w);
        reset   = 1'b0;
        last_rd = 32'h0;
        return;
      end
      if (wb_cyc_o) begin
        cyc_cnt++;
        if (cyc_cnt == n + 1) begin
          beats++;
          wb_ack_i = 1'b1;
          check_eq("beat_adr", 32'(wb_adr_o), 32'(addr[22:2]));
          if (wb_we_o) begin
            slave_mem[int'(wb_adr_o)] = wb_dat_o;
            check_eq("beat_wdat", wb_dat_o, exp_w);
          end else begin
            wb_dat_i = sget(int'(wb_adr_o));
          end
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = $urandom;
        end
      end else begin
        cyc_cnt  = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      if (mem_ready) begin
        done      = 1;
        mem_valid = 1'b0;
        check_eq("latency", 32'(k), 32'(exp_lat));
        check_eq("rdata", mem_rdata, exp_rd);
      end
    end
    wb_ack_i = 1'b0;
    if (!done) check_eq("ready_timeout", 32'd0, 32'd1);
    check_eq("beats", 32'(beats), 32'(exp_beats));
    check_eq("stb_eq_cyc", {31'b0, stb_bad}, 32'd0);
    if (strb == 4'h0) last_rd = old_w;
    else ref_mem[widx] = exp_w;
    check_eq("slave_word", sget(widx), rget(widx));
  endtask

  initial begin
    logic [3:0] strb;
    logic [31:0] a;
    bit bad;
    int r;

    slave_mem[4]  = 32'h12345678; ref_mem[4]  = 32'h12345678;
    slave_mem[12] = 32'h11223344; ref_mem[12] = 32'h11223344;
    slave_mem[13] = 32'hA5A5A5A5; ref_mem[13] = 32'hA5A5A5A5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready0", {31'b0, mem_ready}, 32'd0);
    check_eq("rst_rdata0", mem_rdata, 32'd0);
    check_eq("rst_adr0", 32'(wb_adr_o), 32'd0);
    check_eq("rst_dat0", wb_dat_o, 32'd0);
    check_eq("rst_ctl0", {28'b0, wb_cyc_o, wb_stb_o, wb_we_o, busy}, 32'd0);
    check_eq("rst_err0", {31'b0, err_o}, 32'd0);
    reset = 1'b0;

    run_txn(32'h0300_0010, 32'h0, 4'h0, 3, 0);
    run_txn(32'h0300_0020, 32'hCAFEF00D, 4'hF, 2, 0);
    run_txn(32'h0300_0030, 32'h0000AB00, 4'b0010, 1, 0);
    run_txn(32'h0300_0030, 32'h0, 4'h0, 0, 0);

    // Stray acks while idle plus an out-of-window request must do nothing.
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0200_0000; mem_wstrb = 4'h0; wb_ack_i = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_cyc_o || mem_ready || busy) bad = 1;
    end
    mem_valid = 1'b0; wb_ack_i = 1'b0;
    check_eq("outside_idle", {31'b0, bad}, 32'd0);

    run_txn(32'h0300_0034, 32'h00FF0000, 4'b0100, 2, 1);
    run_txn(32'h0300_0034, 32'h0, 4'h0, 1, 0);

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
    begin
      int k, cyc_n;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 32'h0300_0040; mem_wstrb = 4'h0;
      k = 0; cyc_n = 0;
      while (!mem_ready && k < 100) begin
        @(negedge clk);
        k++;
        if (wb_cyc_o) cyc_n++;
      end
      mem_valid = 1'b0;
      check_eq("to_cyc_cycles", 32'(cyc_n), ToCycles);
      check_eq("to_rdata", mem_rdata, 32'hDEADBEEF);
      check_eq("to_err", {31'b0, err_o}, 32'd1);
      last_rd = 32'hDEADBEEF;
      run_txn(32'h0300_0010, 32'h0, 4'h0, 1, 0);
      check_eq("to_err_sticky", {31'b0, err_o}, 32'd1);
    end
`else
    check_eq("err_tied", {31'b0, err_o}, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = 32'h0300_0000 | (32'($urandom_range(0, 7)) << 2);
      r = $urandom_range(0, 2);
      strb = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(1, 14));
      run_txn(a, $urandom, strb, $urandom_range(0, 4), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
